// File: rtl/iter_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package iter_divider_pkg;

  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] CALC_ENC = 2'd1;
  localparam logic [1:0] DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE = IDLE_ENC,
    CALC = CALC_ENC,
    DONE = DONE_ENC
  } state_e;

  // Counter must be able to hold the value DIVIDEND_WIDTH.
  function automatic int unsigned cnt_width(input int unsigned dividend_width);
    return $clog2(dividend_width + 1);
  endfunction

endpackage

// File: rtl/iter_divider_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module iter_divider_step #(
  parameter int unsigned DIVISOR_WIDTH = 8
) (
  input  logic [DIVISOR_WIDTH:0]   rem_i,
  input  logic                     bit_i,
  input  logic [DIVISOR_WIDTH-1:0] divisor_i,
  output logic [DIVISOR_WIDTH:0]   rem_o,
  output logic                     q_o
);

  localparam int unsigned XW = DIVISOR_WIDTH + 2;

  logic [XW-1:0] shifted;
  logic [XW-1:0] diff;

  // Extra top bit of diff acts as the borrow/sign of the trial subtraction.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - XW'(divisor_i);
    q_o     = ~diff[XW-1];
    rem_o   = q_o ? diff[DIVISOR_WIDTH:0] : shifted[DIVISOR_WIDTH:0];
  end

endmodule

// File: rtl/iter_divider.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional ITER_DIVIDER_EARLY_OUT_EN: finish in one cycle when dividend < divisor.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int unsigned DIVIDEND_WIDTH = 16,
  parameter int unsigned DIVISOR_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);

  localparam int unsigned CNT_WIDTH = cnt_width(DIVIDEND_WIDTH);

  state_e                    state_q, state_d;
  logic [DIVIDEND_WIDTH-1:0] dq_q, dq_d;
  logic [DIVISOR_WIDTH:0]    rem_q, rem_d;
  logic [DIVISOR_WIDTH-1:0]  dvs_q, dvs_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      dbz_q, dbz_d;

  logic [DIVISOR_WIDTH:0]    step_rem;
  logic                      step_q;

  // dq_q shifts dividend bits out at the top while quotient bits enter at the bottom.
  iter_divider_step #(
    .DIVISOR_WIDTH(DIVISOR_WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .bit_i    (dq_q[DIVIDEND_WIDTH-1]),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .q_o      (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dq_q    <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvs_d = divisor;
          cnt_d = '0;
          dbz_d = 1'b0;
          rem_d = '0;
          dq_d  = dividend;
          if (divisor == '0) begin
            state_d = DONE;
            dq_d    = '1;
            rem_d   = {1'b0, dividend[DIVISOR_WIDTH-1:0]};
            dbz_d   = 1'b1;
`ifdef ITER_DIVIDER_EARLY_OUT_EN
          end else if (dividend < DIVIDEND_WIDTH'(divisor)) begin
            state_d = DONE;
            dq_d    = '0;
            rem_d   = {1'b0, dividend[DIVISOR_WIDTH-1:0]};
`endif
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        dq_d  = {dq_q[DIVIDEND_WIDTH-2:0], step_q};
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(DIVIDEND_WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decodes of registered state and registered datapath.
  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    quotient    = dq_q;
    remainder   = rem_q[DIVISOR_WIDTH-1:0];
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: directed cases, then randomized operands vs. an arithmetic model.
module tb_iter_divider;

  localparam int unsigned DW = 16;
  localparam int unsigned VW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  iter_divider #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dbz;
    int unsigned   acc;
    int unsigned   lat;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          rdy_mode = 1;
  int unsigned last_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division; latency counted from the accepting edge.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    exp_t e;
    int unsigned ai, bi;
    ai = a;
    bi = b;
    e.acc = 0;
    if (bi == 0) begin
      e.q   = '1;
      e.r   = a[VW-1:0];
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      e.q   = DW'(ai / bi);
      e.r   = VW'(ai % bi);
      e.dbz = 1'b0;
      e.lat = DW + 1;
`ifdef ITER_DIVIDER_EARLY_OUT_EN
      if (ai < bi) e.lat = 1;
`endif
    end
    return e;
  endfunction

  // Monitor: latency, stability under back-pressure, handshake results, in_ready return.
  logic          seen = 1'b0;
  logic          hold_prev = 1'b0;
  logic          ready_next = 1'b0;
  logic [DW-1:0] h_q;
  logic [VW-1:0] h_r;
  logic          h_dbz;

  always @(negedge clk) begin
    if (rst) begin
      seen       = 1'b0;
      hold_prev  = 1'b0;
      ready_next = 1'b0;
      out_ready  = 1'b0;
    end else begin
      if (ready_next) check("in_ready_after_handshake", 32'(in_ready), 32'd1);
      ready_next = 1'b0;
      if (hold_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_quotient", 32'(quotient), 32'(h_q));
        check("hold_remainder", 32'(remainder), 32'(h_r));
        check("hold_dbz", 32'(div_by_zero), 32'(h_dbz));
      end
      if (out_valid) begin
        check("in_ready_low_while_valid", 32'(in_ready), 32'd0);
        if (!seen) begin
          seen = 1'b1;
          check("result_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) check("latency", cyc - sb[0].acc + 1, sb[0].lat);
        end
      end
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
      if (out_valid && out_ready) begin
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("quotient", 32'(quotient), 32'(e.q));
          check("remainder", 32'(remainder), 32'(e.r));
          check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        end
        seen       = 1'b0;
        hold_prev  = 1'b0;
        ready_next = 1'b1;
      end else if (out_valid) begin
        hold_prev = 1'b1;
        h_q       = quotient;
        h_r       = remainder;
        h_dbz     = div_by_zero;
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  // Present operands until accepted; returns at the negedge after the accepting edge.
  task automatic send(input logic [DW-1:0] a, input logic [VW-1:0] b);
    exp_t e;
    int   t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", 32'(in_ready), 32'd1);
    e        = model(a, b);
    e.acc    = cyc + 1;
    last_acc = e.acc;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain", sb.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d results pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] a;
    logic [VW-1:0] b;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    rdy_mode = 1;
    send(16'd1000, 8'd7);   wait_idle();
    send(16'hFFFF, 8'hFF);  wait_idle();
    send(16'hFFFF, 8'h01);  wait_idle();
    send(16'd5, 8'd0);      wait_idle();
    send(16'd1000, 8'd7);   wait_idle();
    send(16'd3, 8'd10);     wait_idle();

    // Back-pressure: result held, new operands ignored while DONE.
    rdy_mode = 2;
    send(16'd1234, 8'd11);
    begin
      int t = 0;
      while (!out_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("stall_valid_seen", 32'(out_valid), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 16'd999;
      divisor  = 8'd3;
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rdy_mode = 1;
    wait_idle();

    // Reset in the middle of CALC discards the operation.
    send(16'd50000, 8'd3);
    while (cyc < last_acc + 7) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    send(16'd200, 8'd9);
    wait_idle();

    rdy_mode = 0;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       b = '0;
        1, 2, 3: b = VW'($urandom_range(1, 15));
        default: b = VW'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) a = DW'($urandom_range(0, 255));
      else                           a = DW'($urandom);
      send(a, b);
    end
    wait_idle();
    rdy_mode = 1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Sequential restoring divider; the inverse operation of the team's combinational multiplier.
- Recovers one factor from a product and a known factor, and returns the remainder.
- Produces one quotient bit per clock, MSB first, behind valid/ready handshakes on input and output.
- Used on datapaths where a combinational divider's depth would break timing.

Parameters:
- DIVIDEND_WIDTH, 16, width of dividend and quotient.
- DIVISOR_WIDTH, 8, width of divisor and remainder.
- localparam CNT_WIDTH, $clog2(DIVIDEND_WIDTH+1), width of the iteration counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- dividend  in  DIVIDEND_WIDTH  unsigned dividend (product).
- divisor  in  DIVISOR_WIDTH  unsigned divisor (known factor).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  DIVIDEND_WIDTH  unsigned quotient.
- remainder  out  DIVISOR_WIDTH  unsigned remainder.
- div_by_zero  out  1  result came from a zero divisor.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- States:
  - IDLE: in_ready=1. in_valid&in_ready captures dividend, divisor, and clears the partial remainder (DIVISOR_WIDTH+1 bits).
    - divisor==0 → DONE.
    - otherwise → CALC with counter=0.
  - CALC: in_ready=0. Each cycle:
    - shift the next dividend bit (MSB first) into the partial remainder;
    - trial-subtract the divisor;
    - if non-negative, keep the difference and set the quotient bit to 1, else restore and set it to 0;
    - counter++.
    - After DIVIDEND_WIDTH CALC cycles → DONE.
  - DONE: out_valid=1, in_ready=0. Outputs are held stable until out_valid&out_ready, then → IDLE.
- Latency: acceptance at edge T → out_valid high from edge T+DIVIDEND_WIDTH+1. Divide-by-zero gives out_valid from T+1.
- Throughput: one operation at a time; no overlap. in_ready returns the cycle after the output handshake.
- Arithmetic: all unsigned.
  - The remainder always fits DIVISOR_WIDTH bits because it is less than the divisor.
  - The quotient is full DIVIDEND_WIDTH, with no overflow possible.
- Divide by zero: quotient = all ones; remainder = dividend[DIVISOR_WIDTH-1:0]; div_by_zero=1.
- div_by_zero is 0 on every other result.
- in_valid while not in IDLE is ignored; the operands must be held by the producer.
- Outputs must not change while out_valid=1 and out_ready=0.
- A reset asserted in any state (mid-CALC included) returns the block to reset values on the next edge, and the partial result is discarded.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: ITER_DIVIDER_EARLY_OUT_EN.
- Defined: in IDLE, if divisor!=0 and dividend<divisor, go directly to DONE with quotient=0 and remainder=dividend[DIVISOR_WIDTH-1:0] (latency 1).
- Undefined: such operands take the full DIVIDEND_WIDTH CALC cycles and give the identical result.
- div_by_zero=0 in both cases.

Decomposition:
- Package iter_divider_pkg holds:
  - state enum type (IDLE, CALC, DONE);
  - localparam encodings;
  - a function computing CNT_WIDTH.
- One sub-module is natural: iter_divider_step, the combinational shift/trial-subtract/restore for one bit, instantiated once inside the CALC datapath.
- FSM and handshake stay in the top module.

Test Plan:
1. Reset, then dividend=1000, divisor=7 → out_valid at T+17, quotient=142, remainder=6, div_by_zero=0.
2. dividend=0xFFFF, divisor=0xFF → quotient=257, remainder=0; then dividend=0xFFFF, divisor=0x01 → quotient=0xFFFF, remainder=0.
3. dividend=5, divisor=0 → out_valid at T+1, quotient=0xFFFF, remainder=5, div_by_zero=1; the next normal division shows div_by_zero=0.
4. dividend=3, divisor=10 → quotient=0, remainder=3.
   - With ITER_DIVIDER_EARLY_OUT_EN: out_valid at T+1.
   - Without it: out_valid at T+17.
5. Hold out_ready=0 for 5 cycles after out_valid → outputs constant, in_ready=0, a new in_valid is ignored. out_ready=1 → in_ready=1 next cycle.
6. Assert rst at the 8th CALC cycle → next cycle out_valid=0, in_ready=1, outputs 0. A following division of 200/9 returns quotient 22, remainder 2.
